pps_gate_ctrl: RTL and testbench
================================

// Module: pps_gate_ctrl
// PURPOSE
//  Measurement sequencer for the GPSDO frequency-counter path. Synchronises the async 1PPS input into
//  the OCXO clk domain and opens/closes counting gates of 1..15 PPS periods. Counts clk cycles per gate,
//  detects lost PPS and hands each result to the SPI readout side with a valid/ack handshake.
//  Runs gates back-to-back with zero dead time: the closing PPS edge of one gate opens the next.
// PARAMETERS
//  CNT_W      32          result / cycle-counter width
//  GATE_W     4           width of gate_sel (max gate = 2**GATE_W-1 PPS periods)
//  TO_W       28          width of timeout counter
//  TIMEOUT    12_000_000  clk cycles without a PPS edge before pps_lost (1.2 s @ 10 MHz)
// PORTS
//  clk        in   1       OCXO clock
//  rst_n      in   1       reset, asynchronous, active-low
//  pps        in   1       raw 1PPS, asynchronous to clk
//  enable     in   1       level; 1 = run measurements, 0 = abort to IDLE
//  gate_sel   in   GATE_W  PPS periods per gate; 0 treated as 1
//  rd_ack     in   1       1-cycle pulse: consumer has taken result
//  clr_flags  in   1       1-cycle pulse: clears overrun and pps_lost
//  result     out  CNT_W   clk cycles counted over last completed gate
//  result_vld out  1       result holds an unconsumed value
//  result_sat out  1       result saturated at all-ones (qualifies result)
//  overrun    out  1       sticky: result overwritten while result_vld=1
//  pps_lost   out  1       sticky: TIMEOUT expired in ARM or GATE
//  busy       out  1       1 in ARM or GATE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; synchroniser flops 0.
//  Sync: 2-FF synchroniser + edge register; pps_rise = 1-cycle pulse, 3 clk after pps rises.
//  FSM: IDLE -(enable)-> ARM -(pps_rise)-> GATE -(pps_rise & edges==gate_len)-> GATE (result emitted).
//   enable=0 in any state -> IDLE next cycle; partial gate discarded, result/flags untouched.
//   ARM/GATE: timeout counter cleared on pps_rise, else +1; reaching TIMEOUT -> pps_lost=1, state ARM,
//   partial count discarded, no result emitted.
//  gate_len = (gate_sel==0) ? 1 : gate_sel, sampled on each gate-opening pps_rise; mid-gate changes
//   take effect at the next gate.
//  Counting: on gate-opening pps_rise cyc<=1, edges<=0; each other cycle cyc<=cyc+1 (saturating at
//   all-ones, sat flag set); each pps_rise in GATE increments edges.
//   For pulses at cycles t0 and tN, result = tN - t0 exactly.
//  Emit: on closing pps_rise, result<=cyc, result_sat<=sat, result_vld<=1 in the same cycle; that same
//   pps_rise reopens the next gate (cyc<=1).
//  Handshake: rd_ack clears result_vld next cycle. Emit while result_vld=1 and no rd_ack -> overwrite,
//   overrun<=1. Emit and rd_ack in the same cycle -> new result, result_vld stays 1, no overrun.
//   rd_ack while result_vld=0 is ignored.
//  Flags: clr_flags and set in the same cycle -> set wins.
//  Timeout counter saturates at TIMEOUT; it does not wrap.
// STRUCTURE
//  gpsdo_pkg: state enum {IDLE, ARM, GATE}; default TIMEOUT and width constants.
//  Sub-module pps_sync: 2-FF synchroniser + rising-edge detect -> pps_rise.
//  Top level holds the FSM, cycle/edge/timeout counters and the result register.
// TESTING  (clk 10 MHz, TIMEOUT=1000 in sim)
//  1 Basic: PPS period 800 clk, gate_sel=1, enable=1 -> first result 800 after 2nd edge, result_vld=1,
//    result_sat=0.
//  2 Multi-gate: gate_sel=3, period 800 -> result 2400; gate_sel=0 -> result 800.
//  3 Overrun: no rd_ack across 2 emits -> overrun=1, result holds 2nd value; rd_ack coincident with
//    an emit -> overrun stays 0.
//  4 Lost PPS: stop PPS after 1 edge -> pps_lost=1 at 1000 clk after that edge, busy=1, state ARM,
//    no emit; PPS resumes -> results return.
//  5 Abort: enable=0 mid-gate -> IDLE next cycle, busy=0, no emit; re-enable -> ARM, first result
//    after 2 new edges.
//  6 Reset mid-GATE and saturation (CNT_W=8, period 300) -> all outputs 0; result=255, result_sat=1.

Source files
------------

// File: rtl/gpsdo_pkg.sv
// Shared types and default sizing for the GPSDO frequency-counter path.
package gpsdo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } state_t;

    // 1.2 s of OCXO cycles at 10 MHz
    localparam int CNT_W_DEF   = 32;
    localparam int GATE_W_DEF  = 4;
    localparam int TO_W_DEF    = 28;
    localparam int TIMEOUT_DEF = 12_000_000;

endpackage

// File: rtl/pps_sync.sv
// Brings the raw 1PPS into the clk domain and produces a one-cycle rising-edge pulse.
module pps_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pps,
    output logic pps_rise
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // two metastability flops, then an edge register; pps_rise is registered too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            prev_p2  <= 1'b0;
            pps_rise <= 1'b0;
        end else begin
            sync_p0  <= pps;
            sync_p1  <= sync_p0;
            prev_p2  <= sync_p1;
            pps_rise <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/pps_gate_ctrl.sv
// Gate sequencer: counts clk cycles across 1..15 PPS periods, back-to-back, with
// lost-PPS detection and a valid/ack result handoff to the readout side.
module pps_gate_ctrl
    import gpsdo_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GATE_W  = GATE_W_DEF,
    parameter int TO_W    = TO_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pps,
    input  logic              enable,
    input  logic [GATE_W-1:0] gate_sel,
    input  logic              rd_ack,
    input  logic              clr_flags,
    output logic [CNT_W-1:0]  result,
    output logic              result_vld,
    output logic              result_sat,
    output logic              overrun,
    output logic              pps_lost,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

    function automatic logic [GATE_W-1:0] gate_len_f(input logic [GATE_W-1:0] sel);
        return (sel == '0) ? GATE_W'(1) : sel;
    endfunction

    function automatic logic [CNT_W-1:0] cyc_inc_f(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [TO_W-1:0] to_inc_f(input logic [TO_W-1:0] t);
        return (t >= TO_LIMIT) ? TO_LIMIT : t + 1'b1;
    endfunction

    logic              pps_rise;
    state_t            state;
    logic [CNT_W-1:0]  cyc;
    logic              sat;
    logic [GATE_W-1:0] edges;
    logic [GATE_W-1:0] gate_len;
    logic [TO_W-1:0]   to_cnt;
    logic              close_edge;
    logic              to_hit;
    logic              emit;
    logic              lost_set;

    pps_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pps      (pps),
        .pps_rise (pps_rise)
    );

    assign close_edge = pps_rise && ((edges + 1'b1) == gate_len);
    // fires only on the cycle the counter first reaches the limit, so a saturated counter stays quiet
    assign to_hit     = !pps_rise && (to_cnt == TO_LIMIT - 1'b1);
    assign emit       = enable && (state == GATE) && close_edge;
    assign lost_set   = enable && ((state == ARM) || (state == GATE)) && to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cyc      <= '0;
            sat      <= 1'b0;
            edges    <= '0;
            gate_len <= '0;
            to_cnt   <= '0;
        end else if (!enable) begin
            state  <= IDLE;
            busy   <= 1'b0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= ARM;
                    busy   <= 1'b1;
                    to_cnt <= '0;
                end
                ARM: begin
                    if (pps_rise) begin
                        state    <= GATE;
                        cyc      <= CNT_W'(1);
                        sat      <= 1'b0;
                        edges    <= '0;
                        gate_len <= gate_len_f(gate_sel);
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_inc_f(to_cnt);
                    end
                end
                GATE: begin
                    if (pps_rise) begin
                        to_cnt <= '0;
                        // the closing edge of one gate is the opening edge of the next
                        if (close_edge) begin
                            cyc      <= CNT_W'(1);
                            sat      <= 1'b0;
                            edges    <= '0;
                            gate_len <= gate_len_f(gate_sel);
                        end else begin
                            edges <= edges + 1'b1;
                            cyc   <= cyc_inc_f(cyc);
                            sat   <= sat | (cyc == CNT_MAX);
                        end
                    end else if (to_hit) begin
                        state  <= ARM;
                        to_cnt <= to_inc_f(to_cnt);
                    end else begin
                        to_cnt <= to_inc_f(to_cnt);
                        cyc    <= cyc_inc_f(cyc);
                        sat    <= sat | (cyc == CNT_MAX);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // result register and sticky flags; a set on the same cycle as clr_flags wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            result_vld <= 1'b0;
            result_sat <= 1'b0;
            overrun    <= 1'b0;
            pps_lost   <= 1'b0;
        end else begin
            if (emit) begin
                result     <= cyc;
                result_sat <= sat;
                result_vld <= 1'b1;
            end else if (rd_ack) begin
                result_vld <= 1'b0;
            end
            overrun  <= (emit && result_vld && !rd_ack) || (overrun && !clr_flags);
            pps_lost <= lost_set || (pps_lost && !clr_flags);
        end
    end

endmodule

// File: tb/tb_pps_gate_ctrl.sv
// Bench for pps_gate_ctrl: timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pps_gate_ctrl;

    localparam int TIMEOUT = 1000;

    logic        clk;
    logic        rst_n;
    logic        pps_a;
    logic        enable;
    logic [3:0]  gate_sel;
    logic        rd_ack;
    logic        clr_flags;
    logic [31:0] result;
    logic        result_vld;
    logic        result_sat;
    logic        overrun;
    logic        pps_lost;
    logic        busy;

    logic        pps_b;
    logic        en_b;
    logic [3:0]  sel_b;
    logic        ack_b;
    logic        clr_b;
    logic [7:0]  result_b;
    logic        vld_b;
    logic        sat_b;
    logic        ov_b;
    logic        lost_b;
    logic        busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    pps_gate_ctrl #(.CNT_W(32), .GATE_W(4), .TO_W(28), .TIMEOUT(TIMEOUT)) dut_a (
        .clk(clk), .rst_n(rst_n), .pps(pps_a), .enable(enable), .gate_sel(gate_sel),
        .rd_ack(rd_ack), .clr_flags(clr_flags), .result(result), .result_vld(result_vld),
        .result_sat(result_sat), .overrun(overrun), .pps_lost(pps_lost), .busy(busy)
    );

    pps_gate_ctrl #(.CNT_W(8), .GATE_W(4), .TO_W(28), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .rst_n(rst_n), .pps(pps_b), .enable(en_b), .gate_sel(sel_b),
        .rd_ack(ack_b), .clr_flags(clr_b), .result(result_b), .result_vld(vld_b),
        .result_sat(sat_b), .overrun(ov_b), .pps_lost(lost_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // PPS generators: 10-cycle-wide pulses every per cycles starting at cycle start
    int tcyc = 0;
    int per_a = 0, start_a = 0;
    int per_b = 0, start_b = 0;
    initial begin
        pps_a = 1'b0;
        pps_b = 1'b0;
        forever begin
            @(posedge clk);
            tcyc++;
            #1;
            pps_a = (per_a != 0) && (tcyc >= start_a) && (((tcyc - start_a) % per_a) < 10);
            pps_b = (per_b != 0) && (tcyc >= start_b) && (((tcyc - start_b) % per_b) < 10);
        end
    end

    // Reference model for dut_a, built on cycle timestamps
    int          m_n = 0, m_t0 = 0, m_last = 0, m_edges = 0, m_glen = 1, m_st = 0;
    logic        h [4];
    logic [31:0] m_result = '0;
    logic        m_vld = 0, m_sat = 0, m_ov = 0, m_lost = 0, m_busy = 0, m_close_next = 0;

    initial begin
        for (int i = 0; i < 4; i++) h[i] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = 0; m_t0 = 0; m_last = 0; m_edges = 0; m_glen = 1; m_st = 0;
                m_result = '0; m_vld = 0; m_sat = 0; m_ov = 0; m_lost = 0; m_busy = 0;
                m_close_next = 0;
                for (int i = 0; i < 4; i++) h[i] = 1'b0;
            end else begin
                automatic logic   rise = h[2] && !h[3];
                automatic logic   emit = 0, lset = 0, oset = 0;
                automatic longint span = 0;
                m_n++;
                if (!enable) m_st = 0;
                else if (m_st == 0) begin
                    m_st = 1; m_last = m_n;
                end else if (m_st == 1) begin
                    if (rise) begin
                        m_st = 2; m_t0 = m_n; m_edges = 0; m_last = m_n;
                        m_glen = (gate_sel == 0) ? 1 : int'(gate_sel);
                    end else if (m_n - m_last == TIMEOUT) lset = 1;
                end else begin
                    if (rise) begin
                        m_last = m_n;
                        m_edges++;
                        if (m_edges == m_glen) begin
                            emit = 1; span = m_n - m_t0; m_t0 = m_n; m_edges = 0;
                            m_glen = (gate_sel == 0) ? 1 : int'(gate_sel);
                        end
                    end else if (m_n - m_last == TIMEOUT) begin
                        lset = 1; m_st = 1;
                    end
                end
                if (emit) begin
                    oset = m_vld && !rd_ack;
                    m_vld = 1;
                    m_sat = span > 64'hFFFF_FFFF;
                    m_result = m_sat ? 32'hFFFF_FFFF : span[31:0];
                end else if (rd_ack) m_vld = 0;
                m_ov   = oset || (m_ov && !clr_flags);
                m_lost = lset || (m_lost && !clr_flags);
                m_busy = (m_st != 0);
                h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = pps_a;
                m_close_next = (m_st == 2) && h[2] && !h[3] && (m_edges + 1 == m_glen);
            end
        end
    end

    // every-cycle comparison of dut_a against the model
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if ({result, result_vld, result_sat, overrun, pps_lost, busy} !==
                {m_result, m_vld, m_sat, m_ov, m_lost, m_busy}) begin
                n_bad++;
                $display("FAIL model_cmp cyc=%0d got res=%0d vld=%b sat=%b ov=%b lost=%b busy=%b exp res=%0d vld=%b sat=%b ov=%b lost=%b busy=%b",
                         tcyc, result, result_vld, result_sat, overrun, pps_lost, busy,
                         m_result, m_vld, m_sat, m_ov, m_lost, m_busy);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_vld(input int maxc, input string name);
        int c = 0;
        while (!result_vld && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check({name, "_vld"}, result_vld, 1);
    endtask

    task automatic wait_close(input int maxc, input string name);
        int c = 0;
        while (!m_close_next && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check({name, "_close_seen"}, m_close_next, 1);
    endtask

    task automatic pulse_ack();
        @(negedge clk); rd_ack = 1'b1;
        @(negedge clk); rd_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_flags = 1'b1;
        @(negedge clk); clr_flags = 1'b0;
    endtask

    task automatic restart_a(input int per);
        per_a = 0;
        repeat (12) @(negedge clk);
        per_a = per;
        start_a = tcyc + 1;
    endtask

    task automatic restart_b(input int per);
        per_b = 0;
        repeat (12) @(negedge clk);
        per_b = per;
        start_b = tcyc + 1;
    endtask

    initial begin
        #6_000_000;
        n_bad++;
        $display("FAIL watchdog: got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; gate_sel = 4'd1; rd_ack = 1'b0; clr_flags = 1'b0;
        en_b = 1'b0; sel_b = 4'd1; ack_b = 1'b0; clr_b = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_flags", {result_vld, result_sat, overrun, pps_lost, busy}, 0);
        check("rst_b", {result_b, vld_b, sat_b, ov_b, lost_b, busy_b}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // basic single-period gate
        @(negedge clk);
        gate_sel = 4'd1; enable = 1'b1;
        restart_a(800);
        wait_vld(2500, "t1");
        check("t1_result", result, 800);
        check("t1_sat", result_sat, 0);
        check("t1_busy", busy, 1);
        pulse_ack();
        check("t1_vld_clr", result_vld, 0);

        // multi-period gates; the new length applies from the next gate
        gate_sel = 4'd3;
        wait_vld(1000, "t2a"); check("t2a_result", result, 800);  pulse_ack();
        wait_vld(3000, "t2b"); check("t2b_result", result, 2400); pulse_ack();
        gate_sel = 4'd0;
        wait_vld(3000, "t2c"); check("t2c_result", result, 2400); pulse_ack();
        wait_vld(1000, "t2d"); check("t2d_result", result, 800);  pulse_ack();

        // overrun, then an ack coincident with an emit
        wait_vld(1000, "t3a");
        wait_close(1000, "t3a");
        @(negedge clk);
        check("t3_overrun", overrun, 1);
        check("t3_result", result, 800);
        pulse_clr();
        check("t3_ov_clr", overrun, 0);
        wait_close(1000, "t3b");
        rd_ack = 1'b1;
        @(negedge clk); rd_ack = 1'b0;
        check("t3_coinc_ov", overrun, 0);
        check("t3_coinc_vld", result_vld, 1);
        pulse_ack();

        // lost PPS: a single edge, then silence
        enable = 1'b0;
        restart_a(100000);
        enable = 1'b1;
        @(negedge clk);
        begin
            int c = 1;
            while (!pps_lost && c < 3000) begin
                @(negedge clk);
                c++;
            end
            check("t4_lost_latency", c, 1005);
        end
        check("t4_busy", busy, 1);
        check("t4_no_emit", result_vld, 0);
        restart_a(800);
        wait_vld(2500, "t4r");
        check("t4_resume_result", result, 800);
        check("t4_lost_sticky", pps_lost, 1);
        pulse_ack();
        pulse_clr();
        check("t4_lost_clr", pps_lost, 0);

        // abort mid-gate and re-enable
        repeat (400) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t5_busy_off", busy, 0);
        repeat (2000) @(negedge clk);
        check("t5_no_emit", result_vld, 0);
        enable = 1'b1;
        @(negedge clk);
        check("t5_busy_on", busy, 1);
        wait_vld(2500, "t5");
        check("t5_result", result, 800);

        // reset while a result is pending and a gate is open
        repeat (300) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_result", result, 0);
        check("t6_rst_flags", {result_vld, result_sat, overrun, pps_lost, busy}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_vld(2500, "t6");
        check("t6_result", result, 800);
        pulse_ack();

        // 8-bit counter: 300 saturates, 255 just fits
        @(negedge clk);
        en_b = 1'b1;
        restart_b(300);
        begin
            int c = 0;
            while (!vld_b && c < 1000) begin @(negedge clk); c++; end
        end
        check("sat_vld", vld_b, 1);
        check("sat_result", result_b, 255);
        check("sat_flag", sat_b, 1);
        @(negedge clk); ack_b = 1'b1;
        @(negedge clk); ack_b = 1'b0;
        check("sat_ack", vld_b, 0);
        en_b = 1'b0;
        restart_b(255);
        en_b = 1'b1;
        begin
            int c = 0;
            while (!vld_b && c < 1000) begin @(negedge clk); c++; end
        end
        check("edge255_vld", vld_b, 1);
        check("edge255_result", result_b, 255);
        check("edge255_sat", sat_b, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
